// File: rtl/mux_arb_n_pkg.sv
// Shared types and helpers for the N-channel registered mux/arbiter.
package mux_arb_n_pkg;

    typedef enum logic [1:0] {
        MUX_MANUAL = 2'd0,
        MUX_FIXED  = 2'd1,
        MUX_RR     = 2'd2,
        MUX_RSVD   = 2'd3
    } mux_mode_t;

    // Index width for n channels; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // The reserved encoding behaves as round-robin.
    function automatic logic mode_is_rr(input mux_mode_t mode);
        return (mode == MUX_RR) || (mode == MUX_RSVD);
    endfunction

endpackage

// File: rtl/mux_arb_n_if.sv
// Channel-side and consumer-side handshake bundle for mux_arb_n.
interface mux_arb_n_if
    import mux_arb_n_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 32
);
    localparam int SW = sel_width(N);

    logic [N*WIDTH-1:0] d;
    logic [N-1:0]       d_valid;
    logic [N-1:0]       d_ready;
    logic [WIDTH-1:0]   y;
    logic [SW-1:0]      y_sel;
    logic               y_valid;
    logic               y_ready;

    // Producers and consumer drive the master side; the mux is the slave.
    modport master (
        output d, d_valid, y_ready,
        input  d_ready, y, y_sel, y_valid
    );

    modport slave (
        input  d, d_valid, y_ready,
        output d_ready, y, y_sel, y_valid
    );

endinterface

// File: rtl/mux_arb_n_arbiter.sv
// Combinational grant selection: manual index, fixed priority, or round-robin after ptr.
module mux_arb_n_arbiter
    import mux_arb_n_pkg::*;
#(
    parameter int N = 4,
    localparam int SW = sel_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    input  mux_mode_t     mode,
    input  logic [SW-1:0] s,
    output logic [N-1:0]  grant,
    output logic [SW-1:0] gidx
);

    logic found;
    int   idx;

    // An out-of-range manual index simply matches no channel.
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        idx   = 0;
        case (mode)
            MUX_MANUAL: begin
                for (int i = 0; i < N; i++) begin
                    if (!found && (s == SW'(i)) && req[i]) begin
                        found    = 1'b1;
                        grant[i] = 1'b1;
                        gidx     = SW'(i);
                    end
                end
            end
            MUX_FIXED: begin
                for (int i = 0; i < N; i++) begin
                    if (!found && req[i]) begin
                        found    = 1'b1;
                        grant[i] = 1'b1;
                        gidx     = SW'(i);
                    end
                end
            end
            default: begin
                for (int k = 1; k <= N; k++) begin
                    idx = (int'(ptr) + k) % N;
                    if (!found && req[idx]) begin
                        found      = 1'b1;
                        grant[idx] = 1'b1;
                        gidx       = SW'(idx);
                    end
                end
            end
        endcase
    end

endmodule

// File: rtl/mux_arb_n.sv
// N-channel valid/ready mux with a depth-1 full-throughput output register.
module mux_arb_n
    import mux_arb_n_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 32,
    localparam int SW   = sel_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  mux_mode_t     mode,
    input  logic [SW-1:0] sel,
    mux_arb_n_if.slave    bus
);

    logic [N-1:0]     grant;
    logic [SW-1:0]    gidx;
    logic [SW-1:0]    rr_ptr;
    logic             load;
    logic [WIDTH-1:0] chan [N];
    logic [WIDTH-1:0] y_q;
    logic [SW-1:0]    y_sel_q;
    logic             y_valid_q;

    for (genvar i = 0; i < N; i++) begin : g_chan
        assign chan[i] = bus.d[i*WIDTH +: WIDTH];
    end

    mux_arb_n_arbiter #(.N(N)) u_arbiter (
        .req   (bus.d_valid),
        .ptr   (rr_ptr),
        .mode  (mode),
        .s     (sel),
        .grant (grant),
        .gidx  (gidx)
    );

    // Reset is folded in so nothing is acknowledged while it is held.
    assign load = ~rst & enable & (~y_valid_q | bus.y_ready) & (|grant);

    assign bus.d_ready = grant & {N{load}};
    assign bus.y       = y_q;
    assign bus.y_sel   = y_sel_q;
    assign bus.y_valid = y_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q       <= '0;
            y_sel_q   <= '0;
            y_valid_q <= 1'b0;
        end else if (load) begin
            y_q       <= chan[gidx];
            y_sel_q   <= gidx;
            y_valid_q <= 1'b1;
        end else if (bus.y_ready) begin
            y_valid_q <= 1'b0;
        end
    end

    // Pointer starts at N-1 so channel 0 wins the first round-robin pick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= SW'(N - 1);
        end else if (load && mode_is_rr(mode)) begin
            rr_ptr <= gidx;
        end
    end

endmodule
